// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter: client ids, command record
// and the round-robin successor helper.
package mem_req_arbiter_pkg;

    localparam int NUM_MEM_CLIENTS = 3;
    localparam int MEM_ADDR_W      = 16;
    localparam int MEM_DATA_W      = 64;

    typedef enum logic [1:0] {
        CLIENT_DECOMP = 2'd0,
        CLIENT_WBUF   = 2'd1,
        CLIENT_COMP   = 2'd2
    } mem_client_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Successor in the round-robin ring 0 -> 1 -> 2 -> 0.
    function automatic mem_client_e next_client(input mem_client_e c);
        mem_client_e n;
        case (c)
            CLIENT_DECOMP: n = CLIENT_WBUF;
            CLIENT_WBUF:   n = CLIENT_COMP;
            default:       n = CLIENT_DECOMP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_fifo.sv
// Generic synchronous FIFO with registered occupancy count; used as the
// read-tag queue of the memory request arbiter. DEPTH must be a power of 2.
module fifo #(
    parameter type DTYPE = logic,
    parameter int  DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  DTYPE                     din,
    input  logic                     pop,
    output DTYPE                     dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    DTYPE             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DTYPE'('0);
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter between decompressor, weight buffer and compressor
// for the single memory port, with in-order read-response steering.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W          = MEM_ADDR_W,
    parameter int DATA_W          = MEM_DATA_W,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [NUM_MEM_CLIENTS-1:0]            cli_req,
    input  logic [NUM_MEM_CLIENTS-1:0]            cli_we,
    input  logic [NUM_MEM_CLIENTS*ADDR_W-1:0]     cli_addr,
    input  logic [NUM_MEM_CLIENTS*DATA_W-1:0]     cli_wdata,
    output logic [NUM_MEM_CLIENTS-1:0]            cli_ack,
    output logic [DATA_W-1:0]                     cli_rdata,
    output logic [NUM_MEM_CLIENTS-1:0]            cli_rvalid,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic                                  mem_ready,
    input  logic [DATA_W-1:0]                     mem_rdata,
    input  logic                                  mem_valid,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
    output logic                                  err_unexpected
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    mem_client_e                 ptr_r;
    mem_cmd_t                    cmd_r;
    logic                        cmd_valid_r;
    logic                        err_r;
    logic [NUM_MEM_CLIENTS-1:0]  rvalid_r;
    logic [DATA_W-1:0]           rdata_r;

    logic                        can_accept_s;
    logic [NUM_MEM_CLIENTS-1:0]  elig_s;
    logic [NUM_MEM_CLIENTS-1:0]  rot_s;
    logic [NUM_MEM_CLIENTS-1:0]  grant_s;
    logic                        any_s;
    mem_client_e                 win_s;
    mem_client_e                 head_s;
    logic                        push_s;
    logic                        pop_s;
    logic [CNT_W-1:0]            count_s;
    logic                        full_s;
    logic                        empty_s;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign can_accept_s = ~cmd_valid_r | mem_ready;
    assign elig_s = cli_req & {NUM_MEM_CLIENTS{can_accept_s & ~start}}
                  & (cli_we | {NUM_MEM_CLIENTS{~full_s}});

    // Rotate eligibility so bit 0 is the pointer client, then pick the first set bit.
    always_comb begin
        rot_s   = elig_s;
        win_s   = ptr_r;
        any_s   = 1'b0;
        grant_s = 3'b000;
        case (ptr_r)
            CLIENT_DECOMP: rot_s = elig_s;
            CLIENT_WBUF:   rot_s = {elig_s[0], elig_s[2], elig_s[1]};
            CLIENT_COMP:   rot_s = {elig_s[1], elig_s[0], elig_s[2]};
            default:       rot_s = elig_s;
        endcase
        if (rot_s[0]) begin
            win_s = ptr_r;
            any_s = 1'b1;
        end else if (rot_s[1]) begin
            win_s = next_client(ptr_r);
            any_s = 1'b1;
        end else if (rot_s[2]) begin
            win_s = next_client(next_client(ptr_r));
            any_s = 1'b1;
        end else begin
            win_s = ptr_r;
            any_s = 1'b0;
        end
        if (any_s) begin
            grant_s = 3'b001 << win_s;
        end else begin
            grant_s = 3'b000;
        end
    end

    assign push_s = any_s & ~cli_we[win_s];
    assign pop_s  = mem_valid & ~empty_s;

    fifo #(
        .DTYPE (mem_client_e),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (win_s),
        .pop   (pop_s),
        .dout  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Command register: load on grant, retire on mem_ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_r <= 1'b0;
            cmd_r       <= '0;
        end else if (any_s) begin
            cmd_valid_r <= 1'b1;
            cmd_r.we    <= cli_we[win_s];
            cmd_r.addr  <= cli_addr[int'(win_s)*ADDR_W +: ADDR_W];
            cmd_r.wdata <= cli_wdata[int'(win_s)*DATA_W +: DATA_W];
        end else if (mem_ready) begin
            cmd_valid_r <= 1'b0;
        end else begin
            cmd_valid_r <= cmd_valid_r;
        end
    end

    // Round-robin pointer and sticky error; start rewinds both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= CLIENT_DECOMP;
            err_r <= 1'b0;
        end else if (start) begin
            ptr_r <= CLIENT_DECOMP;
            err_r <= 1'b0;
        end else begin
            if (any_s) begin
                ptr_r <= next_client(win_s);
            end
            if (mem_valid && empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Response steering to the client at the head of the tag queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= 3'b000;
            rdata_r  <= DATA_W'(0);
        end else if (pop_s) begin
            rvalid_r <= 3'b001 << head_s;
            rdata_r  <= mem_rdata;
        end else begin
            rvalid_r <= 3'b000;
        end
    end

    assign cli_ack        = grant_s;
    assign cli_rvalid     = rvalid_r;
    assign cli_rdata      = rdata_r;
    assign mem_req        = cmd_valid_r;
    assign mem_we         = cmd_r.we;
    assign mem_addr       = cmd_r.addr;
    assign mem_wdata      = cmd_r.wdata;
    assign outstanding    = count_s;
    assign err_unexpected = err_r;

endmodule
